// File: rtl/ibex_fetch_pkg.sv
// rtl/ibex_fetch_pkg.sv - shared types and helpers for the instruction fetch path
package ibex_fetch_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_GNT = 1'b1
    } fetch_req_state_e;

    localparam logic [31:0] INSTR_ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } fetch_rsp_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & INSTR_ADDR_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/ibex_fetch_req_ctrl_if.sv
// rtl/ibex_fetch_req_ctrl_if.sv - req/gnt/rvalid instruction bus
interface ibex_fetch_req_ctrl_if;

    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (output req, output addr, input gnt, input rvalid, input rdata, input err);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata, output err);

endinterface

// File: rtl/ibex_fetch_outstanding_tracker.sv
// rtl/ibex_fetch_outstanding_tracker.sv - thermometer-coded in-flight request and discard tracking
module ibex_fetch_outstanding_tracker
    import ibex_fetch_pkg::*;
#(
    parameter int unsigned NUM_REQS = 2,
    localparam int unsigned CNT_W = $clog2(NUM_REQS + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                gnt_fire,
    input  logic                gnt_discard,
    input  logic                rvalid,
    input  logic                branch,
    output logic [NUM_REQS-1:0] outstanding,
    output logic                discard_head,
    output logic [CNT_W-1:0]    count
);

    logic [NUM_REQS-1:0] outstanding_q, outstanding_d, out_shift;
    logic [NUM_REQS-1:0] discard_q, discard_d, dis_shift;

    // Retire first, then append, so a same-cycle grant and rvalid keep the count steady.
    always_comb begin
        out_shift = rvalid ? (outstanding_q >> 1) : outstanding_q;
        dis_shift = rvalid ? (discard_q >> 1) : discard_q;
        if (branch) begin
            dis_shift = dis_shift | out_shift;
        end
        outstanding_d = out_shift;
        discard_d     = dis_shift;
        if (gnt_fire) begin
            outstanding_d = (out_shift << 1) | NUM_REQS'(1);
            if (gnt_discard) begin
                discard_d = dis_shift | (outstanding_d & ~out_shift);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            count = count + CNT_W'(outstanding_q[i]);
        end
    end

    assign outstanding  = outstanding_q;
    assign discard_head = discard_q[0];

endmodule

// File: rtl/ibex_fetch_req_ctrl.sv
// rtl/ibex_fetch_req_ctrl.sv - instruction bus initiator feeding the fetch FIFO
module ibex_fetch_req_ctrl
    import ibex_fetch_pkg::*;
#(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    input  logic                   branch_i,
    input  logic [31:0]            addr_i,
    output logic                   busy_o,
    input  logic [NUM_REQS-1:0]    fifo_busy_i,
    output logic                   fifo_clear_o,
    output logic                   fifo_valid_o,
    output logic [31:0]            fifo_addr_o,
    output logic [31:0]            fifo_rdata_o,
    output logic                   fifo_err_o,
    ibex_fetch_req_ctrl_if.master  instr_bus
);

    localparam int unsigned CNT_W = $clog2(NUM_REQS + 1);
    localparam int unsigned SUM_W = $clog2(2 * NUM_REQS + 1);
    localparam logic [SUM_W-1:0] MAX_OUT = SUM_W'(NUM_REQS);

    fetch_req_state_e    state_q, state_d;
    logic [31:0]         fetch_addr_q, fetch_addr_d;
    logic [31:0]         req_addr_q;
    logic                pend_discard_q;
    logic [NUM_REQS-1:0] outstanding;
    logic                discard_head;
    logic [CNT_W-1:0]    n_out;
    logic [SUM_W-1:0]    n_busy;
    logic                can_issue, gnt_fire, gnt_discard;
    fetch_rsp_t          rsp;

    always_comb begin
        n_busy = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            n_busy = n_busy + SUM_W'(fifo_busy_i[i]);
        end
    end

    // A branch bypasses the FIFO occupancy limit since the FIFO is being cleared.
    assign can_issue = req_i & (SUM_W'(n_out) < MAX_OUT)
                     & (branch_i | ((SUM_W'(n_out) + n_busy) < MAX_OUT));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (instr_bus.req && !instr_bus.gnt) state_d = WAIT_GNT;
            WAIT_GNT: if (instr_bus.gnt) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        instr_bus.req  = 1'b0;
        instr_bus.addr = fetch_addr_q;
        case (state_q)
            IDLE: begin
                instr_bus.req  = can_issue;
                instr_bus.addr = branch_i ? word_align(addr_i) : fetch_addr_q;
            end
            WAIT_GNT: begin
                instr_bus.req  = 1'b1;
                instr_bus.addr = req_addr_q;
            end
            default: ;
        endcase
    end

    assign gnt_fire    = instr_bus.req & instr_bus.gnt;
    // A request stuck waiting across a branch is stale once granted.
    assign gnt_discard = (state_q == WAIT_GNT) & (pend_discard_q | branch_i);

    always_comb begin
        fetch_addr_d = fetch_addr_q;
        if (gnt_fire && !gnt_discard) begin
            fetch_addr_d = instr_bus.addr + 32'd4;
        end else if (branch_i) begin
            fetch_addr_d = word_align(addr_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_addr_q   <= '0;
            req_addr_q     <= '0;
            pend_discard_q <= 1'b0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            if (state_q == IDLE && instr_bus.req && !instr_bus.gnt) begin
                req_addr_q <= instr_bus.addr;
            end
            if (gnt_fire) begin
                pend_discard_q <= 1'b0;
            end else if (state_q == WAIT_GNT && branch_i) begin
                pend_discard_q <= 1'b1;
            end
        end
    end

    ibex_fetch_outstanding_tracker #(.NUM_REQS(NUM_REQS)) u_tracker (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .gnt_fire     (gnt_fire),
        .gnt_discard  (gnt_discard),
        .rvalid       (instr_bus.rvalid),
        .branch       (branch_i),
        .outstanding  (outstanding),
        .discard_head (discard_head),
        .count        (n_out)
    );

    assign rsp          = '{rdata: instr_bus.rdata, err: instr_bus.err};
    assign fifo_clear_o = branch_i;
    assign fifo_addr_o  = addr_i;
    assign fifo_valid_o = instr_bus.rvalid & ~discard_head & ~branch_i;
    assign fifo_rdata_o = rsp.rdata;
    assign fifo_err_o   = rsp.err;
    assign busy_o       = instr_bus.req | outstanding[0];

    a_rvalid_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
        instr_bus.rvalid |-> outstanding[0]);
    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        SUM_W'(n_out) <= MAX_OUT);
    a_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == WAIT_GNT && !instr_bus.gnt) |=> (instr_bus.addr == $past(instr_bus.addr)));

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// tb/tb_ibex_fetch_req_ctrl.sv - scoreboard bench for the fetch request controller
module tb_ibex_fetch_req_ctrl;
    import ibex_fetch_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        req_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic        busy_o;
    logic [1:0]  fifo_busy_i = '0;
    logic        fifo_clear_o;
    logic        fifo_valid_o;
    logic [31:0] fifo_addr_o;
    logic [31:0] fifo_rdata_o;
    logic        fifo_err_o;

    ibex_fetch_req_ctrl_if bus ();

    ibex_fetch_req_ctrl #(.NUM_REQS(2)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .branch_i     (branch_i),
        .addr_i       (addr_i),
        .busy_o       (busy_o),
        .fifo_busy_i  (fifo_busy_i),
        .fifo_clear_o (fifo_clear_o),
        .fifo_valid_o (fifo_valid_o),
        .fifo_addr_o  (fifo_addr_o),
        .fifo_rdata_o (fifo_rdata_o),
        .fifo_err_o   (fifo_err_o),
        .instr_bus    (bus.master)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    fetch_rsp_t exp_q[$];
    fetch_rsp_t mon_e;

    always @(negedge clk_i) begin
        if (rst_ni && fifo_valid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL push_unexpected: got push rdata=%h err=%b, want no push", fifo_rdata_o, fifo_err_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (fifo_rdata_o !== mon_e.rdata || fifo_err_o !== mon_e.err) begin
                    errors++;
                    $display("FAIL push_data: got %h/%b want %h/%b", fifo_rdata_o, fifo_err_o, mon_e.rdata, mon_e.err);
                end
            end
        end
    end

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drv(input logic r, input logic b, input logic [31:0] a,
                       input logic g, input logic rv, input logic [31:0] d, input logic e);
        req_i = r; branch_i = b; addr_i = a;
        bus.gnt = g; bus.rvalid = rv; bus.rdata = d; bus.err = e;
    endtask

    task automatic respond(input logic [31:0] d, input logic e, input bit push);
        bus.rvalid = 1'b1; bus.rdata = d; bus.err = e;
        if (push) exp_q.push_back('{rdata: d, err: e});
    endtask

    task automatic test_reset();
        drv(0, 0, 0, 0, 0, 0, 0);
        #2;
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", bus.req); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_o); end
        checks++; if (fifo_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", fifo_valid_o); end
        cyc(); cyc();
        rst_ni = 1'b1;
        cyc();
        #2;
        checks++; if (bus.addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", bus.addr); end
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL rst_req_idle: got %b want 0", bus.req); end
    endtask

    task automatic test_branch_basic();
        cyc(); drv(1, 1, 32'h102, 1, 0, 0, 0); #2;
        checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL br_req: got %b want 1", bus.req); end
        checks++; if (bus.addr !== 32'h100) begin errors++; $display("FAIL br_addr: got %h want 00000100", bus.addr); end
        checks++; if (fifo_clear_o !== 1'b1) begin errors++; $display("FAIL br_clear: got %b want 1", fifo_clear_o); end
        checks++; if (fifo_addr_o !== 32'h102) begin errors++; $display("FAIL br_fifo_addr: got %h want 00000102", fifo_addr_o); end
        cyc(); drv(1, 0, 0, 1, 0, 0, 0); respond(32'hDEADBEEF, 0, 1); #2;
        checks++; if (fifo_clear_o !== 1'b0) begin errors++; $display("FAIL br_clear1: got %b want 0", fifo_clear_o); end
        checks++; if (fifo_valid_o !== 1'b1) begin errors++; $display("FAIL br_valid1: got %b want 1", fifo_valid_o); end
        checks++; if (bus.addr !== 32'h104) begin errors++; $display("FAIL br_next_addr: got %h want 00000104", bus.addr); end
        cyc(); drv(0, 0, 0, 0, 0, 0, 0); respond(dat(32'h104), 0, 1); #2;
        checks++; if (bus.req !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL br_busy: got req=%b busy=%b want 0/1", bus.req, busy_o); end
        cyc(); drv(0, 0, 0, 0, 0, 0, 0); #2;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL br_idle: got busy=%b want 0", busy_o); end
    endtask

    task automatic test_max_outstanding();
        cyc(); drv(1, 1, 32'h100, 1, 0, 0, 0); #2;
        checks++; if (bus.addr !== 32'h100) begin errors++; $display("FAIL max_a0: got %h want 00000100", bus.addr); end
        cyc(); drv(1, 0, 0, 1, 0, 0, 0); #2;
        checks++; if (bus.req !== 1'b1 || bus.addr !== 32'h104) begin errors++; $display("FAIL max_a1: got %b/%h want 1/00000104", bus.req, bus.addr); end
        for (int i = 0; i < 2; i++) begin
            cyc(); drv(1, 0, 0, 1, 0, 0, 0); #2;
            checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL max_hold%0d: got req=%b want 0", i, bus.req); end
        end
        cyc(); drv(1, 0, 0, 1, 0, 0, 0); respond(dat(32'h100), 0, 1); #2;
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL max_rv_cycle: got req=%b want 0", bus.req); end
        cyc(); drv(1, 0, 0, 1, 0, 0, 0); respond(dat(32'h104), 0, 1); #2;
        checks++; if (bus.req !== 1'b1 || bus.addr !== 32'h108) begin errors++; $display("FAIL max_resume: got %b/%h want 1/00000108", bus.req, bus.addr); end
        cyc(); drv(0, 0, 0, 0, 0, 0, 0); respond(dat(32'h108), 0, 1);
        cyc(); drv(0, 0, 0, 0, 0, 0, 0); #2;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL max_idle: got busy=%b want 0", busy_o); end
    endtask

    task automatic test_branch_in_wait();
        cyc(); drv(1, 1, 32'h100, 1, 0, 0, 0);
        cyc(); drv(1, 0, 0, 0, 0, 0, 0); #2;
        checks++; if (bus.req !== 1'b1 || bus.addr !== 32'h104) begin errors++; $display("FAIL bw_req: got %b/%h want 1/00000104", bus.req, bus.addr); end
        cyc(); drv(1, 1, 32'h200, 0, 0, 0, 0); #2;
        checks++; if (bus.addr !== 32'h104 || fifo_clear_o !== 1'b1) begin errors++; $display("FAIL bw_branch: got %h/%b want 00000104/1", bus.addr, fifo_clear_o); end
        cyc(); drv(1, 0, 0, 0, 0, 0, 0); respond(dat(32'h100), 0, 0); #2;
        checks++; if (bus.req !== 1'b1 || bus.addr !== 32'h104) begin errors++; $display("FAIL bw_hold: got %b/%h want 1/00000104", bus.req, bus.addr); end
        cyc(); drv(1, 0, 0, 1, 0, 0, 0); #2;
        checks++; if (bus.addr !== 32'h104) begin errors++; $display("FAIL bw_gnt_addr: got %h want 00000104", bus.addr); end
        cyc(); drv(1, 0, 0, 1, 0, 0, 0); respond(dat(32'h104), 0, 0); #2;
        checks++; if (bus.req !== 1'b1 || bus.addr !== 32'h200) begin errors++; $display("FAIL bw_target: got %b/%h want 1/00000200", bus.req, bus.addr); end
        checks++; if (fifo_valid_o !== 1'b0) begin errors++; $display("FAIL bw_stale: got valid=%b want 0", fifo_valid_o); end
        cyc(); drv(0, 0, 0, 0, 0, 0, 0); respond(dat(32'h200), 0, 1);
        cyc(); drv(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_fifo_busy();
        cyc(); drv(1, 1, 32'h300, 1, 0, 0, 0);
        cyc(); drv(1, 0, 0, 1, 0, 0, 0); fifo_busy_i = 2'b01; #2;
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL fb_block: got req=%b want 0", bus.req); end
        cyc(); drv(1, 0, 0, 1, 0, 0, 0); fifo_busy_i = 2'b00; #2;
        checks++; if (bus.req !== 1'b1 || bus.addr !== 32'h304) begin errors++; $display("FAIL fb_release: got %b/%h want 1/00000304", bus.req, bus.addr); end
        cyc(); drv(0, 0, 0, 0, 0, 0, 0); respond(dat(32'h300), 0, 1);
        cyc(); drv(0, 0, 0, 0, 0, 0, 0); respond(dat(32'h304), 0, 1);
        cyc(); drv(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_addr_wrap();
        cyc(); drv(1, 1, 32'hFFFF_FFFA, 1, 0, 0, 0); #2;
        checks++; if (bus.addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wr_a0: got %h want fffffff8", bus.addr); end
        cyc(); drv(1, 0, 0, 1, 0, 0, 0); respond(dat(32'hFFFF_FFF8), 0, 1); #2;
        checks++; if (bus.addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_a1: got %h want fffffffc", bus.addr); end
        cyc(); drv(1, 0, 0, 1, 0, 0, 0); respond(dat(32'hFFFF_FFFC), 0, 1); #2;
        checks++; if (bus.req !== 1'b1 || bus.addr !== 32'h0) begin errors++; $display("FAIL wr_wrap: got %b/%h want 1/00000000", bus.req, bus.addr); end
        cyc(); drv(0, 0, 0, 0, 0, 0, 0); respond(dat(32'h0), 0, 1);
        cyc(); drv(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_error_resp();
        cyc(); drv(1, 1, 32'h400, 1, 0, 0, 0);
        cyc(); drv(1, 0, 0, 1, 0, 0, 0); respond(32'hBAD0_0400, 1, 1); #2;
        checks++; if (fifo_valid_o !== 1'b1 || fifo_err_o !== 1'b1) begin errors++; $display("FAIL er_push: got %b/%b want 1/1", fifo_valid_o, fifo_err_o); end
        checks++; if (bus.req !== 1'b1 || bus.addr !== 32'h404) begin errors++; $display("FAIL er_continue: got %b/%h want 1/00000404", bus.req, bus.addr); end
        cyc(); drv(0, 0, 0, 0, 0, 0, 0); respond(dat(32'h404), 0, 1);
        cyc(); drv(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        cyc(); drv(1, 1, 32'h500, 0, 0, 0, 0);
        cyc(); drv(1, 0, 0, 0, 0, 0, 0); #2;
        checks++; if (bus.req !== 1'b1 || bus.addr !== 32'h500) begin errors++; $display("FAIL rm_wait: got %b/%h want 1/00000500", bus.req, bus.addr); end
        req_i = 1'b0; rst_ni = 1'b0; #1;
        checks++; if (bus.req !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL rm_async: got req=%b busy=%b want 0/0", bus.req, busy_o); end
        cyc(); rst_ni = 1'b1; drv(1, 0, 0, 0, 0, 0, 0); #2;
        checks++; if (bus.req !== 1'b1 || bus.addr !== 32'h0) begin errors++; $display("FAIL rm_restart: got %b/%h want 1/00000000", bus.req, bus.addr); end
        cyc(); drv(1, 0, 0, 1, 0, 0, 0);
        cyc(); drv(0, 0, 0, 0, 0, 0, 0); respond(dat(32'h0), 0, 1);
        cyc(); drv(0, 0, 0, 0, 0, 0, 0); #2;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rm_idle: got busy=%b want 0", busy_o); end
    endtask

    initial begin
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.err = 1'b0;
        test_reset();
        test_branch_basic();
        test_max_outstanding();
        test_branch_in_wait();
        test_fifo_busy();
        test_addr_wrap();
        test_error_resp();
        test_reset_mid();
        cyc();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_push: got %0d expected pushes left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
